// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button debouncer.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int SYNC_STAGES_DEF     = 2;

endpackage

// File: rtl/sync_ff.sv
// N-stage flip-flop synchroniser for a single asynchronous bit.
module sync_ff #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= {N{RST_VAL}};
    else     ff <= {ff[N-2:0], d};
  end

  assign q = ff[N-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces the active-low ExtBTN pin and emits a one-cycle IntBTN pulse per press.
module button_debouncer
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 5
) (
  input  logic Fg_CLK,
  input  logic RESETn,
  input  logic ExtBTN,
  output logic IntBTN
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  logic             btn_s;
  btn_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             pulse_nxt;

  sync_ff #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
    .clk (Fg_CLK),
    .rst (RESETn),
    .d   (ExtBTN),
    .q   (btn_s)
  );

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  // Counter only runs in the two WAIT states; any other state or a level
  // change leaves it cleared, so each wait starts counting from zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    pulse_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (!btn_s) state_nxt = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (btn_s) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      PRESSED: begin
        if (btn_s) state_nxt = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (!btn_s)                 state_nxt = PRESSED;
        else if (cnt == CNT_LAST)   state_nxt = IDLE;
        else                        cnt_nxt   = cnt_inc;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Fg_CLK or posedge RESETn) begin
    if (RESETn) begin
      state  <= IDLE;
      cnt    <= '0;
      IntBTN <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      IntBTN <= pulse_nxt;
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench: stimulus queues expected pulse cycles, a monitor pops and checks them.
`timescale 1ns/1ps
module tb_button_debouncer;
  import btn_pkg::*;

  localparam int LAT = 19;

  logic Fg_CLK = 1'b0;
  logic RESETn = 1'b1;
  logic ExtBTN = 1'b1;
  logic IntBTN;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_pulse = 0;
  int n_exp   = 0;
  int exp_q[$];
  logic prev_int = 1'b0;

  button_debouncer dut (
    .Fg_CLK (Fg_CLK),
    .RESETn (RESETn),
    .ExtBTN (ExtBTN),
    .IntBTN (IntBTN)
  );

  always #21 Fg_CLK = ~Fg_CLK;
  always @(posedge Fg_CLK) cyc++;

  // Monitor: every observed pulse must match the next queued expectation.
  always @(negedge Fg_CLK) begin
    int exp_t;
    if (IntBTN) begin
      n_pulse++;
      n_cmp++;
      if (prev_int) begin
        n_fail++;
        $display("FAIL pulse_width: IntBTN high two cycles in a row at cyc %0d, required 1-cycle pulse", cyc);
      end
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: pulse at cyc %0d, required none", cyc);
      end else begin
        exp_t = exp_q.pop_front();
        if (cyc != exp_t) begin
          n_fail++;
          $display("FAIL pulse_time: pulse at cyc %0d, required cyc %0d", cyc, exp_t);
        end
      end
    end
    prev_int = IntBTN;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Fg_CLK);
  endtask

  task automatic expect_pulse();
    exp_q.push_back(cyc + LAT);
    n_exp++;
  endtask

  // 10 one-clock bounces ending released, a held low, 10 bounces ending low, then release.
  task automatic bouncy_press(input int hold);
    for (int i = 0; i < 10; i++) begin
      @(negedge Fg_CLK); ExtBTN = ~ExtBTN;
    end
    @(negedge Fg_CLK); ExtBTN = 1'b0; expect_pulse();
    tick(hold);
    for (int i = 0; i < 10; i++) begin
      @(negedge Fg_CLK); ExtBTN = ~ExtBTN;
    end
    @(negedge Fg_CLK); ExtBTN = 1'b1;
    tick(60);
  endtask

  initial begin
    // 1: reset and idle
    tick(5);
    check("reset_intbtn", int'(IntBTN), 0);
    check("reset_state", int'(dut.state), int'(IDLE));
    RESETn = 1'b0;
    tick(100);
    check("idle_intbtn", int'(IntBTN), 0);
    check("idle_state", int'(dut.state), int'(IDLE));

    // 2: clean press
    ExtBTN = 1'b0; expect_pulse();
    tick(40);
    ExtBTN = 1'b1;
    tick(60);

    // 3: bouncy press (~1 us hold)
    bouncy_press(24);

    // 4: glitch shorter than the debounce window
    ExtBTN = 1'b0;
    tick(10);
    ExtBTN = 1'b1;
    tick(60);
    check("glitch_state", int'(dut.state), int'(IDLE));

    // 5: two bouncy presses 400 clocks apart, then a long hold
    bouncy_press(24);
    tick(400);
    bouncy_press(24);
    ExtBTN = 1'b0; expect_pulse();
    tick(2000);
    ExtBTN = 1'b1;
    tick(60);

    // 6a: reset during PRESS_WAIT, button held through reset
    ExtBTN = 1'b0;
    tick(8);
    RESETn = 1'b1;
    #1 check("rst_presswait_intbtn", int'(IntBTN), 0);
    check("rst_presswait_state", int'(dut.state), int'(IDLE));
    tick(3);
    RESETn = 1'b0; expect_pulse();
    tick(40);
    ExtBTN = 1'b1;
    tick(60);

    // 6b: reset during the IntBTN cycle
    ExtBTN = 1'b0; expect_pulse();
    tick(LAT);
    #5 check("pulse_before_rst", int'(IntBTN), 1);
    RESETn = 1'b1;
    #1 check("rst_pulse_intbtn", int'(IntBTN), 0);
    tick(3);
    RESETn = 1'b0; expect_pulse();
    tick(40);
    ExtBTN = 1'b1;
    tick(60);

    // 6c: reset asserted just before the pulse edge suppresses it
    ExtBTN = 1'b0;
    tick(LAT - 1);
    RESETn = 1'b1;
    tick(2);
    ExtBTN = 1'b1;
    RESETn = 1'b0;
    tick(60);
    check("final_state", int'(dut.state), int'(IDLE));

    check("missed_pulses", exp_q.size(), 0);
    check("pulse_total", n_pulse, n_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
